// File: rtl/ttfs_output_decoder.sv
// ttfs_output_decoder: latches first-spike ticks of the output-layer neurons,
// resolves the winning class (earliest tick, ties -> lowest class index) and
// ends the run with a one-cycle inference_done_o pulse. An OBI slave port
// exposes status, valid mask and per-class spike times to the host.
// Build option: define TTFS_DECODER_ALL_SPIKES_EN to keep the run going until
// every class has spiked (or timeout) instead of stopping at the first spike.

package ttfs_decoder_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_rsp_t;
endpackage

// One class slot: holds the valid flag and first-spike tick of one class.
module ttfs_class_slot #(
    parameter int INPUT_RESO = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  clear,
    input  logic                  hit,
    input  logic [INPUT_RESO-1:0] tick,
    output logic                  valid,
    output logic [INPUT_RESO-1:0] spk_time
);
    // first accepted spike wins; a run start wipes the slot
    always_ff @(posedge CLK) begin
        if (!RSTN || clear) begin
            valid    <= 1'b0;
            spk_time <= '0;
        end else if (hit) begin
            valid    <= 1'b1;
            spk_time <= tick;
        end
    end
endmodule

module ttfs_output_decoder #(
    parameter int  M          = 8,
    parameter int  INPUT_RESO = 8,
    parameter int  NUM_OUT    = 10,
    parameter int  OUT_BASE   = 0,
    parameter type req_t      = ttfs_decoder_pkg::obi_req_t,
    parameter type rsp_t      = ttfs_decoder_pkg::obi_rsp_t
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  start_i,
    input  logic [INPUT_RESO-1:0] tick_i,
    input  logic                  next_tick_i,
    input  logic                  spike_i,
    input  logic [M-1:0]          spike_idx_i,
    output logic                  inference_done_o,
    output logic [4:0]            winner_o,
    output logic                  no_spike_o,
    input  req_t                  decoder_slave_req_i,
    output rsp_t                  decoder_slave_resp_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                               state_q, state_d;
    logic [NUM_OUT-1:0]                   valid, hit, acc;
    logic [NUM_OUT-1:0][INPUT_RESO-1:0]   spk_time;
    logic [INPUT_RESO-1:0]                win_time_q;
    logic [4:0]                           cls;
    logic                                 spike_ok, any_acc, timeout, finish;
    logic                                 rvalid_q;
    logic [31:0]                          rdata_q, rd_word;
    logic [5:0]                           word;
    logic                                 unused_req;

    // a spike coincident with a run start belongs to the old run and is dropped
    assign spike_ok = (state_q == RUN) && spike_i && !start_i;
    assign timeout  = (state_q == RUN) && next_tick_i && (tick_i == {INPUT_RESO{1'b1}});

    // decode spike index into a one-hot class hit and its class number
    always_comb begin
        hit = '0;
        cls = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (32'(spike_idx_i) == 32'(OUT_BASE + k)) begin
                hit[k] = 1'b1;
                cls    = 5'(k);
            end
        end
    end

    assign acc     = {NUM_OUT{spike_ok}} & hit & ~valid;
    assign any_acc = |acc;

`ifdef TTFS_DECODER_ALL_SPIKES_EN
    assign finish = timeout || (any_acc && (&(valid | acc)));
`else
    assign finish = timeout || any_acc;
`endif

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        ttfs_class_slot #(.INPUT_RESO(INPUT_RESO)) u_slot (
            .CLK      (CLK),
            .RSTN     (RSTN),
            .clear    (start_i),
            .hit      (acc[k]),
            .tick     (tick_i),
            .valid    (valid[k]),
            .spk_time (spk_time[k])
        );
    end

    // next-state: start always (re)enters RUN, finish closes a run
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (finish) state_d = DONE;
            IDLE,
            DONE:    state_d = state_q;
            default: state_d = IDLE;
        endcase
        if (start_i) state_d = RUN;
    end

    // state, done pulse, winner tracking and no-spike flag
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q          <= IDLE;
            inference_done_o <= 1'b0;
            winner_o         <= '0;
            win_time_q       <= '0;
            no_spike_o       <= 1'b0;
        end else begin
            state_q          <= state_d;
            inference_done_o <= (state_q == RUN) && (state_d == DONE);
            if (start_i) begin
                winner_o   <= '0;
                win_time_q <= '0;
                no_spike_o <= 1'b0;
            end else begin
                // first accept claims the win; an equal-tick lower class steals it
                if (any_acc && ((valid == '0) || ((tick_i == win_time_q) && (cls < winner_o)))) begin
                    winner_o   <= cls;
                    win_time_q <= tick_i;
                end
                if (timeout) no_spike_o <= ((valid | acc) == '0);
            end
        end
    end

    assign word = decoder_slave_req_i.addr[7:2];

    // host-visible word map: status, mask, then one time word per class
    always_comb begin
        rd_word = '0;
        if (word == 6'd0) begin
            rd_word = {(state_q == DONE), no_spike_o, 25'b0, winner_o};
        end else if (word == 6'd1) begin
            rd_word = 32'(valid);
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (32'(word) == 32'(k + 2)) rd_word = 32'(spk_time[k]);
            end
        end
    end

    // response beat one cycle after grant; writes return zero
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= decoder_slave_req_i.req;
            if (decoder_slave_req_i.req) rdata_q <= decoder_slave_req_i.we ? 32'h0 : rd_word;
        end
    end

    // grant is immediate, the slave never stalls
    always_comb begin
        decoder_slave_resp_o        = '0;
        decoder_slave_resp_o.gnt    = decoder_slave_req_i.req;
        decoder_slave_resp_o.rvalid = rvalid_q;
        decoder_slave_resp_o.rdata  = rdata_q;
    end

    assign unused_req = ^{decoder_slave_req_i.wdata, decoder_slave_req_i.be,
                          decoder_slave_req_i.addr[31:8], decoder_slave_req_i.addr[1:0]};
endmodule

// File: tb/tb_ttfs_output_decoder.sv
// Bench for ttfs_output_decoder: directed scenarios plus randomized runs
// checked against a class-level reference model (winner = argmin of times).
module tb_ttfs_output_decoder;
    import ttfs_decoder_pkg::*;

    localparam int M          = 8;
    localparam int INPUT_RESO = 8;
    localparam int NUM_OUT    = 10;
    localparam int OUT_BASE   = 2;
`ifdef TTFS_DECODER_ALL_SPIKES_EN
    localparam bit ALL_EN = 1'b1;
`else
    localparam bit ALL_EN = 1'b0;
`endif

    logic       clk = 1'b0, rstn = 1'b0;
    logic       start = 1'b0, next_tick = 1'b0, spike = 1'b0;
    logic [7:0] tick = '0, spike_idx = '0;
    logic       done, no_spike;
    logic [4:0] winner;
    obi_req_t   req;
    obi_rsp_t   rsp;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    ttfs_output_decoder #(
        .M(M), .INPUT_RESO(INPUT_RESO), .NUM_OUT(NUM_OUT), .OUT_BASE(OUT_BASE),
        .req_t(obi_req_t), .rsp_t(obi_rsp_t)
    ) dut (
        .CLK(clk), .RSTN(rstn), .start_i(start), .tick_i(tick), .next_tick_i(next_tick),
        .spike_i(spike), .spike_idx_i(spike_idx), .inference_done_o(done),
        .winner_o(winner), .no_spike_o(no_spike),
        .decoder_slave_req_i(req), .decoder_slave_resp_o(rsp)
    );

    // reference model: per-class first-spike record plus run/done flags
    bit m_run, m_done, m_nospike, m_pulse;
    bit m_valid[NUM_OUT];
    int m_time[NUM_OUT];

    function automatic int m_winner();
        int w = 0;
        int best = 1 << 30;
        for (int k = 0; k < NUM_OUT; k++)
            if (m_valid[k] && m_time[k] < best) begin best = m_time[k]; w = k; end
        return w;
    endfunction

    function automatic logic [31:0] m_word(input int w);
        logic [31:0] v = '0;
        if (w == 0) v = {m_done, m_nospike, 25'b0, 5'(m_winner())};
        else if (w == 1) begin
            for (int k = 0; k < NUM_OUT; k++) v[k] = m_valid[k];
        end else if (w >= 2 && w < 2 + NUM_OUT) v = 32'(m_time[w-2]);
        return v;
    endfunction

    function automatic void model_clk(input bit st, input int tk, input bit nt, input bit sp, input int idx);
        int  c, cnt;
        bit  accd, fin;
        accd = 0; fin = 0; cnt = 0;
        m_pulse = 0;
        if (st) begin
            m_run = 1; m_done = 0; m_nospike = 0;
            for (int k = 0; k < NUM_OUT; k++) begin m_valid[k] = 0; m_time[k] = 0; end
            return;
        end
        if (!m_run) return;
        c = idx - OUT_BASE;
        if (sp && c >= 0 && c < NUM_OUT && !m_valid[c]) begin
            m_valid[c] = 1; m_time[c] = tk; accd = 1;
        end
        for (int k = 0; k < NUM_OUT; k++) cnt += int'(m_valid[k]);
        if (nt && tk == 255) begin fin = 1; m_nospike = (cnt == 0); end
        if (accd && (!ALL_EN || cnt == NUM_OUT)) fin = 1;
        if (fin) begin m_run = 0; m_done = 1; m_pulse = 1; end
    endfunction

    task automatic cycle(input bit st, input int tk, input bit nt, input bit sp, input int idx);
        @(negedge clk);
        start = st; tick = 8'(tk); next_tick = nt; spike = sp; spike_idx = 8'(idx);
        @(posedge clk);
        model_clk(st, tk, nt, sp, idx);
        #1;
        start = 0; next_tick = 0; spike = 0;
    endtask

    task automatic obi_xfer(input int w, input bit we, output bit g, output bit rv_pre,
                            output bit rv, output logic [31:0] rd, output bit rv_post);
        @(negedge clk);
        req.req = 1'b1; req.we = we; req.addr = 32'(w) << 2; req.wdata = $urandom; req.be = 4'hF;
        #1;
        g = rsp.gnt; rv_pre = rsp.rvalid;
        @(posedge clk);
        model_clk(0, int'(tick), 0, 0, 0);
        #1;
        rv = rsp.rvalid; rd = rsp.rdata;
        @(negedge clk);
        req = '0;
        @(posedge clk);
        model_clk(0, int'(tick), 0, 0, 0);
        #1;
        rv_post = rsp.rvalid;
    endtask

    task automatic test_reset();
        bit g, rp, rv, ra;
        logic [31:0] rd;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({done, winner, no_spike, rsp} !== '0) begin
            bad++; $display("FAIL reset_outputs: got done=%b win=%0d ns=%b rsp=%h want all 0", done, winner, no_spike, rsp);
        end
        @(negedge clk); rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 0);
            total++;
            if (done !== 1'b0) begin bad++; $display("FAIL reset_no_done: got %b want 0", done); end
        end
        obi_xfer(0, 0, g, rp, rv, rd, ra);
        total++;
        if (rd !== 32'h0 || rv !== 1'b1 || g !== 1'b1) begin
            bad++; $display("FAIL reset_status: got rdata=%h rv=%b gnt=%b want 00000000 1 1", rd, rv, g);
        end
    endtask

    task automatic test_single_spike();
        bit g, rp, rv, ra;
        logic [31:0] rd;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 5, 0, 1, OUT_BASE + 3);
        total++;
        if (winner !== 5'd3 || done !== !ALL_EN) begin
            bad++; $display("FAIL single_spike: got win=%0d done=%b want 3 %b", winner, done, !ALL_EN);
        end
        cycle(0, 5, 0, 0, 0);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b want 0", done); end
        obi_xfer(2 + 3, 0, g, rp, rv, rd, ra);
        total++;
        if (rd !== 32'd5) begin bad++; $display("FAIL single_time3: got %h want 5", rd); end
    endtask

    task automatic test_timeout();
        bit g, rp, rv, ra;
        logic [31:0] rd;
        cycle(1, 250, 0, 0, 0);
        cycle(0, 254, 1, 0, 0);
        cycle(0, 255, 0, 1, OUT_BASE + NUM_OUT);
        cycle(0, 255, 0, 1, OUT_BASE - 1);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL timeout_early: got done=%b want 0", done); end
        cycle(0, 255, 1, 0, 0);
        total++;
        if (done !== 1'b1 || no_spike !== 1'b1) begin
            bad++; $display("FAIL timeout_done: got done=%b ns=%b want 1 1", done, no_spike);
        end
        cycle(0, 3, 0, 1, OUT_BASE);
        total++;
        if (done !== 1'b0 || winner !== 5'd0) begin
            bad++; $display("FAIL done_spike_ignored: got done=%b win=%0d want 0 0", done, winner);
        end
        obi_xfer(0, 0, g, rp, rv, rd, ra);
        total++;
        if (rd !== 32'hC000_0000) begin bad++; $display("FAIL timeout_status: got %h want c0000000", rd); end
        obi_xfer(1, 0, g, rp, rv, rd, ra);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL timeout_mask: got %h want 0", rd); end
    endtask

    task automatic test_tie();
        bit g, rp, rv, ra;
        logic [31:0] rd;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 7, 0, 1, OUT_BASE + 6);
        cycle(0, 7, 0, 1, OUT_BASE + 2);
        total++;
        if (winner !== (ALL_EN ? 5'd2 : 5'd6)) begin
            bad++; $display("FAIL tie_winner: got %0d want %0d", winner, ALL_EN ? 2 : 6);
        end
        obi_xfer(1, 0, g, rp, rv, rd, ra);
        total++;
        if (rd !== (ALL_EN ? 32'h044 : 32'h040)) begin
            bad++; $display("FAIL tie_mask: got %h want %h", rd, ALL_EN ? 32'h044 : 32'h040);
        end
    endtask

    task automatic test_all_classes();
        bit g, rp, rv, ra;
        logic [31:0] rd;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < NUM_OUT; i++) begin
            cycle(0, i + 1, 1, 1, OUT_BASE + i);
            total++;
            if (done !== (ALL_EN ? (i == NUM_OUT - 1) : (i == 0))) begin
                bad++; $display("FAIL all_done_at_%0d: got %b want %b", i, done, ALL_EN ? (i == NUM_OUT - 1) : (i == 0));
            end
        end
        obi_xfer(1, 0, g, rp, rv, rd, ra);
        total++;
        if (rd !== (ALL_EN ? 32'h3FF : 32'h001)) begin
            bad++; $display("FAIL all_mask: got %h want %h", rd, ALL_EN ? 32'h3FF : 32'h001);
        end
        obi_xfer(2 + 9, 0, g, rp, rv, rd, ra);
        total++;
        if (rd !== (ALL_EN ? 32'd10 : 32'd0)) begin
            bad++; $display("FAIL all_time9: got %h want %h", rd, ALL_EN ? 32'd10 : 32'd0);
        end
        total++;
        if (winner !== 5'd0) begin bad++; $display("FAIL all_winner: got %0d want 0", winner); end
    endtask

    task automatic test_restart();
        bit g, rp, rv, ra;
        logic [31:0] rd;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 3, 0, 1, OUT_BASE + 4);
        cycle(0, 4, 0, 1, OUT_BASE + 1);
        cycle(1, 4, 0, 1, OUT_BASE + 5);
        total++;
        if (winner !== 5'd0 || done !== 1'b0 || no_spike !== 1'b0) begin
            bad++; $display("FAIL restart_clear: got win=%0d done=%b ns=%b want 0 0 0", winner, done, no_spike);
        end
        obi_xfer(1, 0, g, rp, rv, rd, ra);
        total++;
        if (rd !== 32'h0 || g !== 1'b1 || rp !== 1'b0 || rv !== 1'b1 || ra !== 1'b0) begin
            bad++; $display("FAIL restart_mask_timing: got rd=%h gnt=%b rv=%b%b%b want 0 1 010", rd, g, rp, rv, ra);
        end
        obi_xfer(0, 0, g, rp, rv, rd, ra);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL restart_status: got %h want 0", rd); end
        obi_xfer(0, 1, g, rp, rv, rd, ra);
        total++;
        if (rd !== 32'h0 || rv !== 1'b1 || g !== 1'b1) begin
            bad++; $display("FAIL write_ack: got rd=%h rv=%b gnt=%b want 0 1 1", rd, rv, g);
        end
        cycle(0, 6, 0, 1, OUT_BASE + 5);
        obi_xfer(2 + 5, 0, g, rp, rv, rd, ra);
        total++;
        if (rd !== 32'd6 || winner !== 5'd5) begin
            bad++; $display("FAIL restart_live: got time5=%h win=%0d want 6 5", rd, winner);
        end
    endtask

    task automatic test_random();
        int tk, pct, idx;
        bit nt, sp, st, g, rp, rv, ra;
        logic [31:0] rd, exp;
        for (int r = 0; r < 25; r++) begin
            tk  = $urandom_range(180, 250);
            pct = (r % 4 == 0) ? 0 : $urandom_range(5, 40);
            cycle(1, tk, 0, 0, 0);
            for (int c = 0; c < 400 && m_run; c++) begin
                nt  = $urandom_range(0, 1) == 1;
                sp  = $urandom_range(0, 99) < pct;
                idx = $urandom_range(0, 15);
                st  = $urandom_range(0, 59) == 0;
                cycle(st, tk, nt, sp, idx);
                total++;
                if (done !== m_pulse || winner !== 5'(m_winner()) || no_spike !== m_nospike) begin
                    bad++; $display("FAIL rand_cycle r%0d: got done=%b win=%0d ns=%b want %b %0d %b",
                                    r, done, winner, no_spike, m_pulse, m_winner(), m_nospike);
                end
                if (st) tk = $urandom_range(180, 250);
                else if (nt && tk < 255) tk++;
            end
            cycle(0, tk, 0, 1, $urandom_range(0, 15));
            for (int w = 0; w < NUM_OUT + 3; w++) begin
                exp = m_word(w);
                obi_xfer(w, 0, g, rp, rv, rd, ra);
                total++;
                if (rd !== exp || rv !== 1'b1) begin
                    bad++; $display("FAIL rand_read r%0d w%0d: got %h rv=%b want %h 1", r, w, rd, rv, exp);
                end
            end
            obi_xfer(63, 0, g, rp, rv, rd, ra);
            total++;
            if (rd !== 32'h0) begin bad++; $display("FAIL rand_unmapped: got %h want 0", rd); end
        end
    endtask

    initial begin
        req = '0;
        m_run = 0; m_done = 0; m_nospike = 0; m_pulse = 0;
        for (int k = 0; k < NUM_OUT; k++) begin m_valid[k] = 0; m_time[k] = 0; end
        test_reset();
        test_single_spike();
        test_timeout();
        test_tie();
        test_all_classes();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish by %0t want finish", $time);
        $fatal(1);
    end
endmodule
